change_dispenser: RTL and testbench

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/change_dispenser.sv | 131 +++++++++++++
 tb/tb_change_dispenser.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Greedy coin-return FSM: loads the piggy-bank credit on refund and pays it out one coin per handshake.
// Build option: CHANGE_PENNY_SKIP_EN drops pennies and discards any remainder below 5 cents.
module change_dispenser (
    input  logic       clk,
    input  logic       reset,
    input  logic       refund,
    input  logic [7:0] credit,
    input  logic       coin_ready,
    output logic       coin_valid,
    output logic [1:0] coin_type,
    output logic       clear_credit,
    output logic       busy,
    output logic       done
);

    localparam int unsigned CREDIT_W = 8;

`ifdef CHANGE_PENNY_SKIP_EN
    localparam logic [CREDIT_W-1:0] MIN_COIN = CREDIT_W'(5);
`else
    localparam logic [CREDIT_W-1:0] MIN_COIN = CREDIT_W'(1);
`endif

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPENSE = 2'd1,
        DONE     = 2'd2
    } state_t;

    state_t              state, state_n;
    logic [CREDIT_W-1:0] remaining, remaining_n;
    logic [CREDIT_W-1:0] after_coin;
    logic                coin_valid_n;
    logic [1:0]          coin_type_n;
    logic                clear_credit_n;
    logic                busy_n;
    logic                done_n;

    // Largest denomination not exceeding the amount; pennies never chosen when the skip build is on
    // because dispensing only continues while the amount is at least MIN_COIN.
    function automatic logic [1:0] pick_coin(input logic [CREDIT_W-1:0] amt);
        if (amt >= CREDIT_W'(25))      pick_coin = 2'd3;
        else if (amt >= CREDIT_W'(10)) pick_coin = 2'd2;
        else if (amt >= CREDIT_W'(5))  pick_coin = 2'd1;
        else                           pick_coin = 2'd0;
    endfunction

    function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] ct);
        case (ct)
            2'd3:    coin_value = CREDIT_W'(25);
            2'd2:    coin_value = CREDIT_W'(10);
            2'd1:    coin_value = CREDIT_W'(5);
            default: coin_value = CREDIT_W'(1);
        endcase
    endfunction

    assign after_coin = remaining - coin_value(coin_type);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            remaining    <= '0;
            coin_valid   <= 1'b0;
            coin_type    <= 2'd0;
            clear_credit <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_n;
            remaining    <= remaining_n;
            coin_valid   <= coin_valid_n;
            coin_type    <= coin_type_n;
            clear_credit <= clear_credit_n;
            busy         <= busy_n;
            done         <= done_n;
        end
    end

    // Next-state and next-output logic; every output is the registered image of these values.
    always_comb begin
        state_n        = state;
        remaining_n    = remaining;
        coin_valid_n   = 1'b0;
        coin_type_n    = coin_type;
        clear_credit_n = 1'b0;
        done_n         = 1'b0;

        case (state)
            IDLE: begin
                if (refund) begin
                    clear_credit_n = (credit != '0);
                    if (credit >= MIN_COIN) begin
                        state_n      = DISPENSE;
                        remaining_n  = credit;
                        coin_valid_n = 1'b1;
                        coin_type_n  = pick_coin(credit);
                    end else begin
                        state_n     = DONE;
                        remaining_n = '0;
                        done_n      = 1'b1;
                    end
                end
            end
            DISPENSE: begin
                coin_valid_n = 1'b1;
                if (coin_ready) begin
                    if (after_coin < MIN_COIN) begin
                        // Any sub-nickel remainder in the skip build is dropped here.
                        state_n      = DONE;
                        remaining_n  = '0;
                        coin_valid_n = 1'b0;
                        done_n       = 1'b1;
                    end else begin
                        remaining_n = after_coin;
                        coin_type_n = pick_coin(after_coin);
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n     = IDLE;
                remaining_n = '0;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed table, reset corner case and randomized refunds.
module tb_change_dispenser;

    logic       clk;
    logic       reset;
    logic       refund;
    logic [7:0] credit;
    logic       coin_ready;
    logic       coin_valid;
    logic [1:0] coin_type;
    logic       clear_credit;
    logic       busy;
    logic       done;

    change_dispenser dut (
        .clk          (clk),
        .reset        (reset),
        .refund       (refund),
        .credit       (credit),
        .coin_ready   (coin_ready),
        .coin_valid   (coin_valid),
        .coin_type    (coin_type),
        .clear_credit (clear_credit),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Observations of the latest refund run.
    int obs_coins[$];
    int exp_coins[$];
    int obs_clear;
    int obs_busy;
    int obs_done_cyc;
    int obs_last_xfer;
    int obs_stall_err;
    int obs_valid_in_done;
    int obs_got_done;

    typedef struct {
        int credit;
        int stall_first;
        int n_coins;
        int n_clear;
        int busy_cycles;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference: greedy change from plain arithmetic on the loaded credit.
    task automatic model(input int c);
        int r;
        r = c;
        exp_coins.delete();
        for (int i = 0; i < r / 25; i++) exp_coins.push_back(3);
        r = r % 25;
        for (int i = 0; i < r / 10; i++) exp_coins.push_back(2);
        r = r % 10;
        for (int i = 0; i < r / 5; i++) exp_coins.push_back(1);
        r = r % 5;
`ifndef CHANGE_PENNY_SKIP_EN
        for (int i = 0; i < r; i++) exp_coins.push_back(0);
`endif
    endtask

    // One refund transaction; scramble drives random refund/credit noise while the block is busy.
    task automatic run_refund(input int c, input int stall_first, input int stall_pct, input bit scramble);
        int  cyc;
        int  stalls;
        bit  rdy;
        bit  prev_stall;
        int  prev_type;
        obs_coins.delete();
        obs_clear = 0; obs_busy = 0; obs_done_cyc = -1; obs_last_xfer = 0;
        obs_stall_err = 0; obs_valid_in_done = 0; obs_got_done = 0;
        stalls = stall_first; prev_stall = 0; prev_type = 0;
        @(negedge clk);
        credit = 8'(c); refund = 1'b1; coin_ready = 1'b0;
        @(negedge clk);
        refund = 1'b0;
        cyc = 1;
        while (cyc < 400 && obs_got_done == 0) begin
            if (clear_credit) obs_clear++;
            if (busy) obs_busy++;
            if (done) begin
                obs_got_done = 1; obs_done_cyc = cyc;
                if (coin_valid) obs_valid_in_done = 1;
            end
            if (coin_valid && prev_stall && int'(coin_type) != prev_type) obs_stall_err++;
            if (stalls > 0) begin
                rdy = 1'b0; stalls--;
            end else begin
                rdy = ($urandom_range(0, 99) >= stall_pct);
            end
            coin_ready = rdy;
            if (coin_valid && rdy) begin
                obs_coins.push_back(int'(coin_type));
                obs_last_xfer = cyc;
            end
            prev_stall = coin_valid && !rdy;
            prev_type  = int'(coin_type);
            if (scramble) begin
                refund = 1'($urandom_range(0, 1));
                credit = 8'($urandom_range(0, 255));
            end
            @(negedge clk);
            cyc++;
        end
        refund = 1'b0;
        coin_ready = 1'b0;
    endtask

    // Compare the latest run against the model and the generic timing rules.
    task automatic check_run(input int c, input string tag);
        model(c);
        check({tag, " done_seen"}, obs_got_done, 1);
        check({tag, " n_coins"}, obs_coins.size(), exp_coins.size());
        for (int i = 0; i < exp_coins.size() && i < obs_coins.size(); i++)
            check({tag, " coin_seq"}, obs_coins[i], exp_coins[i]);
        check({tag, " clear_pulses"}, obs_clear, (c > 0) ? 1 : 0);
        check({tag, " done_latency"}, obs_done_cyc, (exp_coins.size() > 0) ? obs_last_xfer + 1 : 1);
        check({tag, " busy_cycles"}, obs_busy, obs_done_cyc);
        check({tag, " stall_hold"}, obs_stall_err, 0);
        check({tag, " valid_in_done"}, obs_valid_in_done, 0);
        check({tag, " idle_after"}, {30'd0, busy, done}, 0);
    endtask

    vec_t vecs[$];

    initial begin
        int bad;
        reset = 1'b1; refund = 1'b0; credit = 8'd0; coin_ready = 1'b0;
        #1;
        check("reset_outputs", {27'd0, coin_valid, coin_type, clear_credit, busy, done}, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

`ifdef CHANGE_PENNY_SKIP_EN
        vecs.push_back('{99, 0, 5, 1, 6});
        vecs.push_back('{255, 0, 11, 1, 12});
        vecs.push_back('{40, 3, 3, 1, 7});
        vecs.push_back('{0, 0, 0, 0, 1});
        vecs.push_back('{33, 0, 2, 1, 3});
        vecs.push_back('{3, 0, 0, 1, 1});
`else
        vecs.push_back('{99, 0, 9, 1, 10});
        vecs.push_back('{255, 0, 11, 1, 12});
        vecs.push_back('{40, 3, 3, 1, 7});
        vecs.push_back('{0, 0, 0, 0, 1});
        vecs.push_back('{1, 0, 1, 1, 2});
        vecs.push_back('{4, 2, 4, 1, 7});
`endif
        for (int i = 0; i < vecs.size(); i++) begin
            run_refund(vecs[i].credit, vecs[i].stall_first, 0, 1'b0);
            check($sformatf("vec%0d n_coins", i), obs_coins.size(), vecs[i].n_coins);
            check($sformatf("vec%0d clear", i), obs_clear, vecs[i].n_clear);
            check($sformatf("vec%0d busy", i), obs_busy, vecs[i].busy_cycles);
            check_run(vecs[i].credit, $sformatf("vec%0d", i));
        end

        // Reset mid-refund: outputs fall asynchronously, no done pulse, nothing resumes.
        @(negedge clk);
        credit = 8'd60; refund = 1'b1; coin_ready = 1'b1;
        @(negedge clk);
        refund = 1'b0;
        check("rst_seq valid_c1", {30'd0, coin_valid, busy}, 3);
        @(negedge clk);
        coin_ready = 1'b0;
        check("rst_seq after_xfer", {29'd0, coin_valid, coin_type}, 7);
        #2 reset = 1'b1;
        #1;
        check("rst_seq async_drop", {27'd0, coin_valid, coin_type, clear_credit, busy, done}, 0);
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        coin_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (done || busy || coin_valid) bad++;
        end
        check("rst_seq stays_idle", bad, 0);
        run_refund(5, 0, 0, 1'b0);
        check_run(5, "post_reset");
        check("post_reset nickel", (obs_coins.size() > 0) ? obs_coins[0] : -1, 1);

        // Randomized refunds with stalls and noise on refund/credit while busy.
        for (int n = 0; n < 40; n++) begin
            int c;
            c = (n < 4) ? n * 85 : $urandom_range(0, 255);
            if (c > 255) c = 255;
            run_refund(c, $urandom_range(0, 2), 30, 1'b1);
            check_run(c, $sformatf("rnd%0d c=%0d", n, c));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
